// File: rtl/bp_me_mem_responder.sv
// bp_me_mem_responder
//   Single-outstanding BedRock-style memory responder. It accepts one memory command,
//   waits latency_p cycles, then reads or writes an internal block-wide storage array and
//   returns one response. The response is held until the initiator consumes it with yumi.
//   Reads return the addressed 2^size-byte field replicated across the whole block.
//   Writes merge the low 2^size bytes of the command data at the size-aligned offset.
//   Storage is not cleared by reset.
//
// Ports
//   clk_i, reset_n_i          clock and synchronous active-low reset
//   mem_cmd_*                 command channel (valid / ready_and handshake)
//   mem_resp_*                response channel (valid / yumi); every field is registered
//
// Configuration
//   BP_ME_MEM_RESPONDER_BOUNDS_EN
//     Defined: an out-of-range address or an oversize request suppresses the access and
//     returns all-ones data, and a $error is raised in simulation.
//     Undefined: upper address bits are ignored, so the index wraps, and oversize
//     requests are clamped to a full block.

module bp_me_mem_responder #(
    parameter int unsigned paddr_width_p   = 40,
    parameter int unsigned block_width_p   = 512,
    parameter int unsigned els_p           = 1024,
    parameter int unsigned payload_width_p = 8,
    parameter int unsigned latency_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       mem_cmd_v_i,
    output logic                       mem_cmd_ready_and_o,
    input  logic [1:0]                 mem_cmd_type_i,
    input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
    input  logic [2:0]                 mem_cmd_size_i,
    input  logic [payload_width_p-1:0] mem_cmd_payload_i,
    input  logic [block_width_p-1:0]   mem_cmd_data_i,
    output logic                       mem_resp_v_o,
    input  logic                       mem_resp_yumi_i,
    output logic [1:0]                 mem_resp_type_o,
    output logic [paddr_width_p-1:0]   mem_resp_addr_o,
    output logic [2:0]                 mem_resp_size_o,
    output logic [payload_width_p-1:0] mem_resp_payload_o,
    output logic [block_width_p-1:0]   mem_resp_data_o
);

    localparam int unsigned block_bytes_lp = block_width_p / 8;
    localparam int unsigned lg_bytes_lp    = $clog2(block_bytes_lp);
    localparam int unsigned lg_els_lp      = $clog2(els_p);
    localparam logic [2:0]  max_size_lp    = 3'(lg_bytes_lp);
    // The counter is loaded one short so the e_wait -> e_resp move happens when it hits 0.
    localparam logic [7:0]  cnt_load_lp    = (latency_p == 0) ? 8'd0 : 8'(latency_p - 1);

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e                     state_q, state_d;
    logic                       ready_q, ready_d;
    logic                       resp_v_q, resp_v_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [1:0]                 type_q, type_d;
    logic [paddr_width_p-1:0]   addr_q, addr_d;
    logic [2:0]                 size_q, size_d;
    logic [payload_width_p-1:0] payload_q, payload_d;
    // Holds the command write data while waiting, then the response data.
    logic [block_width_p-1:0]   data_q, data_d;

    logic [block_width_p-1:0]   mem_q [els_p];

    logic                       cmd_hs;
    logic                       acc_go, acc_wr, acc_we, oob;
    logic [paddr_width_p-1:0]   acc_addr;
    logic [2:0]                 acc_size, eff_size;
    logic [block_width_p-1:0]   acc_wdata, cur_blk, rd_blk, wr_blk, resp_blk;
    logic [lg_els_lp-1:0]       acc_idx;
    int unsigned                fld_bytes, fld_off;

    // ready_q is low during reset, so a handshake can only happen while the port shows ready.
    assign cmd_hs = mem_cmd_v_i & ready_q;

    // With zero latency the access happens on the accept edge, straight from the inputs.
    always_comb begin
        if (latency_p == 0) begin
            acc_go    = cmd_hs;
            acc_wr    = mem_cmd_type_i[0];
            acc_addr  = mem_cmd_addr_i;
            acc_size  = mem_cmd_size_i;
            acc_wdata = mem_cmd_data_i;
        end else begin
            acc_go    = (state_q == e_wait) && (cnt_q == 8'd0);
            acc_wr    = type_q[0];
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_wdata = data_q;
        end
    end

    assign eff_size = (acc_size > max_size_lp) ? max_size_lp : acc_size;
    assign acc_idx  = acc_addr[lg_bytes_lp +: lg_els_lp];
    assign cur_blk  = mem_q[acc_idx];

`ifdef BP_ME_MEM_RESPONDER_BOUNDS_EN
    localparam logic [paddr_width_p-1:0] limit_lp =
        paddr_width_p'(64'(els_p) * 64'(block_bytes_lp));
    assign oob = (acc_addr >= limit_lp) || (acc_size > max_size_lp);
`else
    assign oob = 1'b0;
    // Address bits above the index are deliberately ignored so the index wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[paddr_width_p-1:lg_bytes_lp+lg_els_lp];
`endif

    // Field extraction (replicated) and write merge at the size-aligned byte offset.
    always_comb begin
        fld_bytes = 32'd1 << eff_size;
        fld_off   = 32'(acc_addr[lg_bytes_lp-1:0]) & ~(fld_bytes - 32'd1);
        rd_blk    = '0;
        wr_blk    = cur_blk;
        for (int unsigned b = 0; b < block_bytes_lp; b++) begin
            rd_blk[8*b +: 8] = cur_blk[8*(fld_off + (b & (fld_bytes - 32'd1))) +: 8];
            if ((b >= fld_off) && (b < fld_off + fld_bytes)) begin
                wr_blk[8*b +: 8] = acc_wdata[8*(b - fld_off) +: 8];
            end
        end
    end

    assign resp_blk = oob ? '1 : (acc_wr ? '0 : rd_blk);
    // A reset in the commit cycle drops the write.
    assign acc_we   = acc_go & acc_wr & ~oob & reset_n_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        addr_d    = addr_q;
        size_d    = size_q;
        payload_d = payload_q;
        data_d    = data_q;
        unique case (state_q)
            e_ready: begin
                if (cmd_hs) begin
                    type_d    = mem_cmd_type_i;
                    addr_d    = mem_cmd_addr_i;
                    size_d    = mem_cmd_size_i;
                    payload_d = mem_cmd_payload_i;
                    data_d    = mem_cmd_data_i;
                    cnt_d     = cnt_load_lp;
                    state_d   = e_wait;
                    if (latency_p == 0) begin
                        data_d  = resp_blk;
                        state_d = e_resp;
                    end
                end
            end
            e_wait: begin
                if (cnt_q == 8'd0) begin
                    data_d  = resp_blk;
                    state_d = e_resp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            e_resp: begin
                if (mem_resp_yumi_i) begin
                    state_d = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
        ready_d  = (state_d == e_ready);
        resp_v_d = (state_d == e_resp);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= e_ready;
            ready_q   <= 1'b0;
            resp_v_q  <= 1'b0;
            cnt_q     <= '0;
            type_q    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            payload_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            resp_v_q  <= resp_v_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            payload_q <= payload_d;
            data_q    <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_we) begin
            mem_q[acc_idx] <= wr_blk;
        end
    end

`ifdef BP_ME_MEM_RESPONDER_BOUNDS_EN
`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_n_i && acc_go && oob) begin
            $error("bp_me_mem_responder: out-of-bounds access addr=%h size=%0d",
                   acc_addr, acc_size);
        end
    end
`endif
`endif

    assign mem_cmd_ready_and_o = ready_q;
    assign mem_resp_v_o        = resp_v_q;
    assign mem_resp_type_o     = type_q;
    assign mem_resp_addr_o     = addr_q;
    assign mem_resp_size_o     = size_q;
    assign mem_resp_payload_o  = payload_q;
    assign mem_resp_data_o     = data_q;

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// Bench for bp_me_mem_responder: directed scenarios plus randomized traffic, each
// response compared with a byte-array reference model of the storage.

module tb_bp_me_mem_responder;

    localparam int LAT = 4;
    localparam int ELS = 1024;
    localparam int NB  = 16;  // blocks exercised by the bench

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_v, cmd_ready;
    logic [1:0]   cmd_type;
    logic [39:0]  cmd_addr;
    logic [2:0]   cmd_size;
    logic [7:0]   cmd_payload;
    logic [511:0] cmd_data;
    logic         resp_v, resp_yumi;
    logic [1:0]   resp_type;
    logic [39:0]  resp_addr;
    logic [2:0]   resp_size;
    logic [7:0]   resp_payload;
    logic [511:0] resp_data;

    int  checks = 0;
    int  errs   = 0;
    time acc_t;

    logic [7:0] mref [NB][64];

    bp_me_mem_responder #(
        .paddr_width_p  (40),
        .block_width_p  (512),
        .els_p          (ELS),
        .payload_width_p(8),
        .latency_p      (LAT)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .mem_cmd_v_i        (cmd_v),
        .mem_cmd_ready_and_o(cmd_ready),
        .mem_cmd_type_i     (cmd_type),
        .mem_cmd_addr_i     (cmd_addr),
        .mem_cmd_size_i     (cmd_size),
        .mem_cmd_payload_i  (cmd_payload),
        .mem_cmd_data_i     (cmd_data),
        .mem_resp_v_o       (resp_v),
        .mem_resp_yumi_i    (resp_yumi),
        .mem_resp_type_o    (resp_type),
        .mem_resp_addr_o    (resp_addr),
        .mem_resp_size_o    (resp_size),
        .mem_resp_payload_o (resp_payload),
        .mem_resp_data_o    (resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] ref_read(input logic [39:0] a, input int s);
        logic [511:0] r;
        int n   = 1 << s;
        int blk = int'((a / 64) % ELS);
        int off = int'(a % 64);
        off = off - (off % n);
        for (int b = 0; b < 64; b++) r[8*b +: 8] = mref[blk][off + (b % n)];
        return r;
    endfunction

    task automatic ref_write(input logic [39:0] a, input int s, input logic [511:0] d);
        int n   = 1 << s;
        int blk = int'((a / 64) % ELS);
        int off = int'(a % 64);
        off = off - (off % n);
        for (int i = 0; i < n; i++) mref[blk][off + i] = d[8*i +: 8];
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue(input logic [1:0] t, input logic [39:0] a, input logic [2:0] s,
                         input logic [7:0] p, input logic [511:0] d);
        int n = 0;
        @(negedge clk);
        cmd_v = 1'b1; cmd_type = t; cmd_addr = a; cmd_size = s; cmd_payload = p; cmd_data = d;
        while (!cmd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        acc_t = $time;
        #1 cmd_v = 1'b0;
    endtask

    task automatic collect(input logic [1:0] t, input logic [39:0] a, input logic [2:0] s,
                           input logic [7:0] p, input logic [511:0] exp, input int hold,
                           input bit poke);
        int lat = 0;
        while (!resp_v && lat < 64) begin
            @(posedge clk);
            #1 lat++;
            if (!resp_v) check("ready_in_wait", cmd_ready, 0);
        end
        check("latency", lat, LAT);
        check("resp_v", resp_v, 1);
        check("ready_in_resp", cmd_ready, 0);
        check("resp_type", resp_type, t);
        check("resp_addr", resp_addr, a);
        check("resp_size", resp_size, s);
        check("resp_payload", resp_payload, p);
        check("resp_data", resp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke) cmd_v = 1'b1;
            @(posedge clk);
            #1;
            check("hold_v", resp_v, 1);
            check("hold_ready", cmd_ready, 0);
            check("hold_data", resp_data, exp);
        end
        @(negedge clk);
        cmd_v     = 1'b0;
        resp_yumi = 1'b1;
        @(posedge clk);
        #1 resp_yumi = 1'b0;
        check("post_yumi_v", resp_v, 0);
        check("post_yumi_ready", cmd_ready, 1);
    endtask

    task automatic xact(input logic [1:0] t, input logic [39:0] a, input logic [2:0] s,
                        input logic [7:0] p, input logic [511:0] d, input int hold);
        logic [511:0] exp;
        issue(t, a, s, p, d);
        if (t[0]) begin
            exp = '0;
            ref_write(a, int'(s), d);
        end else begin
            exp = ref_read(a, int'(s));
        end
        collect(t, a, s, p, exp, hold, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] d, exp;
        logic [39:0]  a;
        logic [1:0]   t;
        logic [2:0]   s;
        time          prev_t;

        rst_n = 1'b0; cmd_v = 1'b0; resp_yumi = 1'b0;
        cmd_type = '0; cmd_addr = '0; cmd_size = '0; cmd_payload = '0; cmd_data = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_resp_v", resp_v, 0);
        check("rst_data", resp_data, 0);
        check("rst_addr", resp_addr, 0);
        check("rst_payload", resp_payload, 0);
        check("rst_type", resp_type, 0);
        check("rst_size", resp_size, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_ready", cmd_ready, 1);
        check("release_resp_v", resp_v, 0);

        // Preload exercised blocks with full-block writes; block 3 gets bytes 0x00..0x3F
        for (int b = 0; b < NB; b++) begin
            d = rand_blk();
            if (b == 3) for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
            xact(2'd1, 40'(b * 64), 3'd6, 8'(b), d, 0);
        end

        // Full-block read of block 3
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        issue(2'd0, 40'hC0, 3'd6, 8'h5A, '0);
        collect(2'd0, 40'hC0, 3'd6, 8'h5A, d, 0, 1'b0);

        // Sub-block write then uncached read of the same word
        xact(2'd1, 40'h104, 3'd2, 8'h11, 512'hDEADBEEF, 0);
        issue(2'd2, 40'h104, 3'd2, 8'h22, '0);
        collect(2'd2, 40'h104, 3'd2, 8'h22, {16{32'hDEADBEEF}}, 0, 1'b0);
        xact(2'd0, 40'h100, 3'd6, 8'h33, '0, 0);

        // Response held for 20 cycles with a competing command offered
        issue(2'd0, 40'h2C8, 3'd3, 8'h44, '0);
        collect(2'd0, 40'h2C8, 3'd3, 8'h44, ref_read(40'h2C8, 3), 20, 1'b1);

        // Back-to-back reads with same-cycle yumi
        for (int i = 0; i < 8; i++) begin
            a = 40'($urandom_range(0, NB * 64 - 1));
            s = 3'($urandom_range(0, 6));
            issue(2'd0, a, s, 8'(i), '0);
            if (i > 0) check("b2b_period", 64'(acc_t - prev_t), 64'((LAT + 2) * 10));
            prev_t = acc_t;
            collect(2'd0, a, s, 8'(i), ref_read(a, int'(s)), 0, 1'b0);
        end

        // Reset while a write to 0x200 is waiting; the write must not commit
        issue(2'd3, 40'h200, 3'd3, 8'h55, rand_blk());
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", cmd_ready, 0);
        check("midrst_resp_v", resp_v, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst_resp_v", resp_v, 0);
        check("after_rst_ready", cmd_ready, 1);
        xact(2'd0, 40'h200, 3'd6, 8'h66, '0, 0);

        // Read one block past the end of storage
        issue(2'd0, 40'(ELS * 64), 3'd6, 8'h77, '0);
`ifdef BP_ME_MEM_RESPONDER_BOUNDS_EN
        exp = '1;
`else
        exp = ref_read(40'h0, 6);
`endif
        collect(2'd0, 40'(ELS * 64), 3'd6, 8'h77, exp, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            t = 2'($urandom_range(0, 3));
            s = 3'($urandom_range(0, 6));
            a = 40'($urandom_range(0, NB * 64 - 1));
`ifndef BP_ME_MEM_RESPONDER_BOUNDS_EN
            a = a | (40'($urandom_range(0, 255)) << 16);
`endif
            xact(t, a, s, 8'($urandom), rand_blk(), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
